// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: microcode bit
// positions, sequencer state encoding, trap cause codes and the NOP word.
package core_pkg;

  // Bit positions inside the 16-bit microcode word from the decoder ROM.
  localparam int UC_HAS_RD      = 0;
  localparam int UC_HAS_RS1     = 1;
  localparam int UC_HAS_RS2     = 2;
  localparam int UC_MEM         = 3;
  localparam int UC_MEM_WRITE   = 4;
  localparam int UC_PC_REDIRECT = 5;
  localparam int UC_ENV         = 6;
  localparam int UC_ILLEGAL     = 7;

  // Sequencer states, one per phase of a multi-cycle instruction.
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_IWAIT  = 4'd1,
    ST_DECODE = 4'd2,
    ST_RREAD  = 4'd3,
    ST_EXEC   = 4'd4,
    ST_MREQ   = 4'd5,
    ST_MWAIT  = 4'd6,
    ST_WB     = 4'd7,
    ST_TRAP   = 4'd8
  } seq_state_t;

  // Trap cause codes reported on trap_cause.
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_ENV     = 2'd2;
  localparam logic [1:0] CAUSE_BUS     = 2'd3;

  // addi x0, x0, 0 -- harmless contents of the instruction register at reset.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/microcode_sequencer.sv
// Multi-cycle control FSM for the RV32I core. Fetches over a valid/ready
// instruction port, holds the instruction register for the decoder, waits
// out the ROM latency and then steps register read, execute, memory and
// writeback as the microcode word enables them. Owns the PC and trap state.
// Optional feature: define SEQ_PERF_CNT_EN to add the instret counter port.
module microcode_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  input  logic [15:0] microcode,
  output logic        rf_rd_en,
  output logic        alu_en,
  input  logic        branch_taken,
  input  logic [31:0] target_pc,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  input  logic        dmem_rsp_valid,
  output logic        rf_wr_en,
  output logic [31:0] pc,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  // The wait counter trips on the cycle it would reach MEM_TIMEOUT.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  seq_state_t  state;
  seq_state_t  state_next;
  logic [31:0] pc_q;
  logic [31:0] next_pc_q;
  logic [31:0] exec_pc;
  logic [31:0] instr_q;
  logic [5:0]  uc_q;
  logic [1:0]  cause_q;
  logic [1:0]  cause_next;
  logic [7:0]  wait_cnt;
  logic        wait_clr;
  logic        wait_inc;
  logic        wait_expired;
  logic        retire;
  logic        unused_microcode;

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign trap_cause = cause_q;

  assign wait_expired = (wait_cnt == TIMEOUT_LAST);
  assign exec_pc      = (uc_q[UC_PC_REDIRECT] && branch_taken) ? target_pc : pc_q + 32'd4;

  // Upper microcode bits belong to the datapath; rs flags are only needed in DECODE.
  assign unused_microcode = ^{microcode[15:8], uc_q[UC_HAS_RS2:UC_HAS_RS1]};

  // State register; reset lands in FETCH from anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Next-state selection plus the wait-counter and retire controls.
  always_comb begin
    state_next = state;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    retire     = 1'b0;
    cause_next = CAUSE_NONE;
    case (state)
      ST_FETCH: begin
        if (imem_req_valid && imem_req_ready) begin
          state_next = ST_IWAIT;
          wait_clr   = 1'b1;
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_BUS;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_IWAIT: begin
        if (imem_rsp_valid) begin
          state_next = ST_DECODE;
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_BUS;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_DECODE: begin
        if (microcode[UC_ILLEGAL]) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (microcode[UC_ENV]) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ENV;
        end else if (microcode[UC_HAS_RS1] || microcode[UC_HAS_RS2]) begin
          state_next = ST_RREAD;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_RREAD: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (uc_q[UC_MEM]) begin
          state_next = ST_MREQ;
          wait_clr   = 1'b1;
        end else if (uc_q[UC_HAS_RD]) begin
          state_next = ST_WB;
        end else begin
          state_next = ST_FETCH;
          retire     = 1'b1;
          wait_clr   = 1'b1;
        end
      end
      ST_MREQ: begin
        if (dmem_req_valid && dmem_req_ready) begin
          state_next = ST_MWAIT;
          wait_clr   = 1'b1;
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_BUS;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_MWAIT: begin
        if (dmem_rsp_valid) begin
          if (uc_q[UC_HAS_RD]) begin
            state_next = ST_WB;
          end else begin
            state_next = ST_FETCH;
            retire     = 1'b1;
            wait_clr   = 1'b1;
          end
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_BUS;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_WB: begin
        state_next = ST_FETCH;
        retire     = 1'b1;
        wait_clr   = 1'b1;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Registered Moore strobes, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req_valid <= 1'b0;
      rf_rd_en       <= 1'b0;
      alu_en         <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_we        <= 1'b0;
      rf_wr_en       <= 1'b0;
      trap           <= 1'b0;
    end else begin
      imem_req_valid <= (state_next == ST_FETCH);
      rf_rd_en       <= (state_next == ST_RREAD);
      alu_en         <= (state_next == ST_EXEC);
      dmem_req_valid <= (state_next == ST_MREQ);
      dmem_we        <= (state_next == ST_MREQ) && uc_q[UC_MEM_WRITE];
      rf_wr_en       <= (state_next == ST_WB);
      trap           <= (state_next == ST_TRAP);
    end
  end

  // Instruction register, latched microcode, PC, trap cause and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      uc_q      <= '0;
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      cause_q   <= CAUSE_NONE;
      wait_cnt  <= '0;
    end else begin
      if (state == ST_IWAIT && imem_rsp_valid) instr_q <= imem_rsp_data;
      if (state == ST_DECODE) uc_q <= microcode[5:0];
      if (state == ST_EXEC) next_pc_q <= exec_pc;
      if (retire) pc_q <= (state == ST_EXEC) ? exec_pc : next_pc_q;
      if (state != ST_TRAP && state_next == ST_TRAP) cause_q <= cause_next;
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Retired-instruction counter; trapping instructions never retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + 32'd1;
  end
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer. Expected retire records are
// computed from the stimulus, queued, and popped when the DUT retires.
module tb_microcode_sequencer;
  import core_pkg::*;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          MEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic [15:0] microcode;
  logic        rf_rd_en;
  logic        alu_en;
  logic        branch_taken;
  logic [31:0] target_pc;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic        dmem_rsp_valid;
  logic        rf_wr_en;
  logic [31:0] pc;
  logic        trap;
  logic [1:0]  trap_cause;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret;
`endif

  microcode_sequencer #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .microcode(microcode),
    .rf_rd_en(rf_rd_en), .alu_en(alu_en),
    .branch_taken(branch_taken), .target_pc(target_pc),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_rsp_valid(dmem_rsp_valid), .rf_wr_en(rf_wr_en),
    .pc(pc), .trap(trap), .trap_cause(trap_cause)
`ifdef SEQ_PERF_CNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  cycles;
    logic [3:0]  rd;
    logic [3:0]  alu;
    logic [3:0]  dv;
    logic [3:0]  wr;
    logic        we;
  } retire_t;

  retire_t     sb[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          retired      = 0;
  logic [31:0] model_pc;

  // Expected outcome of one instruction, from its microcode and bus behaviour.
  function automatic retire_t model(input logic [31:0] start_pc, input logic [31:0] iword,
                                    input logic [15:0] uc, input logic taken,
                                    input logic [31:0] tgt, input int delay);
    retire_t m;
    int      rs;
    rs       = (uc[1] | uc[2]) ? 1 : 0;
    m.pc     = (uc[5] && taken) ? tgt : start_pc + 32'd4;
    m.instr  = iword;
    m.rd     = 4'(rs);
    m.alu    = 4'd1;
    m.wr     = uc[0] ? 4'd1 : 4'd0;
    m.dv     = uc[3] ? 4'(delay + 1) : 4'd0;
    m.we     = uc[3] & uc[4];
    m.cycles = 8'(5 + rs + (uc[3] ? delay + 2 : 0) + (uc[0] ? 1 : 0));
    return m;
  endfunction

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    microcode      = 16'h0080;
    branch_taken   = 1'b0;
    target_pc      = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    model_pc = RESET_PC;
    retired  = 0;
  endtask

  // Plays the memory/decoder side for one instruction until it retires or traps.
  task automatic drive_instr(input logic [31:0] iword, input logic [15:0] uc, input logic taken,
                             input logic [31:0] tgt, input int delay, input bit stop_mwait,
                             output retire_t obs, output bit trapped);
    bit fetched = 0, responded = 0, mem_acc = 0, mem_rsp = 0, done = 0;
    int cyc = 0, dcnt = 0;
    obs = '0;
    trapped = 0;
    branch_taken = taken;
    target_pc = tgt;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      if (trap) begin
        trapped = 1;
        done = 1;
      end else if (responded && imem_req_valid) begin
        done = 1;
      end else begin
        if (rf_rd_en) obs.rd = obs.rd + 4'd1;
        if (alu_en)   obs.alu = obs.alu + 4'd1;
        if (rf_wr_en) obs.wr = obs.wr + 4'd1;
        if (!fetched && imem_req_valid) begin
          imem_req_ready = 1'b1;
          fetched = 1;
        end else if (fetched && !responded) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = iword;
          microcode      = uc;
          responded      = 1;
        end
        if (dmem_req_valid) begin
          obs.dv = obs.dv + 4'd1;
          obs.we = obs.we | dmem_we;
          if (dcnt == delay) begin
            dmem_req_ready = 1'b1;
            mem_acc = 1;
          end
          dcnt++;
        end else if (mem_acc && !mem_rsp) begin
          if (stop_mwait) begin
            done = 1;
          end else begin
            dmem_rsp_valid = 1'b1;
            mem_rsp = 1;
          end
        end
      end
    end
    obs.pc     = pc;
    obs.instr  = instr;
    obs.cycles = 8'(cyc);
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drive_bound: instr %h never completed, got no retire, required retire within 200 cycles", iword);
    end else if (!trapped && !stop_mwait) begin
      retired++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({imem_req_valid, rf_rd_en, alu_en, dmem_req_valid, dmem_we, rf_wr_en, trap} !== 7'b0 ||
        pc !== RESET_PC || instr !== NOP_INSTR || trap_cause !== CAUSE_NONE) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got strobes=%b pc=%h instr=%h cause=%0d, required 0 %h %h 0",
               {imem_req_valid, rf_rd_en, alu_en, dmem_req_valid, dmem_we, rf_wr_en, trap},
               pc, instr, trap_cause, RESET_PC, NOP_INSTR);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
      tests_failed++;
      $display("[TB] FAIL reset_fetch: got valid=%b addr=%h, required 1 %h", imem_req_valid, imem_addr, RESET_PC);
    end
`ifdef SEQ_PERF_CNT_EN
    tests_run++;
    if (instret !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL instret_reset: got %0d, required 0", instret);
    end
`endif
    model_pc = RESET_PC;
  endtask

  task automatic test_addi();
    retire_t obs, exp;
    bit      tr;
    do_reset();
    exp = model(model_pc, 32'h0010_0093, 16'h0003, 1'b0, 32'h0, 0);
    sb.push_back(exp);
    model_pc = exp.pc;
    drive_instr(32'h0010_0093, 16'h0003, 1'b0, 32'h0, 0, 0, obs, tr);
    exp = sb.pop_front();
    tests_run++;
    if (obs !== exp || tr) begin
      tests_failed++;
      $display("[TB] FAIL addi: got pc=%h instr=%h cyc=%0d rd=%0d alu=%0d dv=%0d wr=%0d we=%b trap=%b, required pc=%h instr=%h cyc=%0d rd=%0d alu=%0d dv=%0d wr=%0d we=%b trap=0",
               obs.pc, obs.instr, obs.cycles, obs.rd, obs.alu, obs.dv, obs.wr, obs.we, tr,
               exp.pc, exp.instr, exp.cycles, exp.rd, exp.alu, exp.dv, exp.wr, exp.we);
    end
    tests_run++;
    if (obs.pc !== 32'd4 || obs.cycles !== 8'd7) begin
      tests_failed++;
      $display("[TB] FAIL addi_timing: got pc=%h at cycle %0d, required 00000004 at cycle 7", obs.pc, obs.cycles);
    end
  endtask

  task automatic test_branch();
    logic [31:0] t_instr[5] = '{32'h0020_8063, 32'h0020_8063, 32'h0010_0093, 32'h0020_8063, 32'h1234_50b7};
    logic [15:0] t_uc[5]    = '{16'h0026, 16'h0026, 16'h0003, 16'h0026, 16'h0001};
    logic        t_taken[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_tgt[5]   = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0500, 32'hFFFF_FFFC, 32'h0000_0300};
    retire_t     obs, exp;
    bit          tr;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp = model(model_pc, t_instr[i], t_uc[i], t_taken[i], t_tgt[i], 0);
      sb.push_back(exp);
      model_pc = exp.pc;
      drive_instr(t_instr[i], t_uc[i], t_taken[i], t_tgt[i], 0, 0, obs, tr);
      exp = sb.pop_front();
      tests_run++;
      if (obs !== exp || tr) begin
        tests_failed++;
        $display("[TB] FAIL branch_%0d: got pc=%h instr=%h cyc=%0d rd=%0d alu=%0d dv=%0d wr=%0d we=%b trap=%b, required pc=%h instr=%h cyc=%0d rd=%0d alu=%0d dv=%0d wr=%0d we=%b trap=0",
                 i, obs.pc, obs.instr, obs.cycles, obs.rd, obs.alu, obs.dv, obs.wr, obs.we, tr,
                 exp.pc, exp.instr, exp.cycles, exp.rd, exp.alu, exp.dv, exp.wr, exp.we);
      end
    end
  endtask

  task automatic test_memory();
    logic [31:0] t_instr[3] = '{32'h0020_A023, 32'h0000_A083, 32'h0020_A223};
    logic [15:0] t_uc[3]    = '{16'h001E, 16'h000B, 16'h001E};
    int          t_delay[3] = '{3, 0, 1};
    retire_t     obs, exp;
    bit          tr;
    for (int i = 0; i < 3; i++) begin
      exp = model(model_pc, t_instr[i], t_uc[i], 1'b0, 32'h0, t_delay[i]);
      sb.push_back(exp);
      model_pc = exp.pc;
      drive_instr(t_instr[i], t_uc[i], 1'b0, 32'h0, t_delay[i], 0, obs, tr);
      exp = sb.pop_front();
      tests_run++;
      if (obs !== exp || tr) begin
        tests_failed++;
        $display("[TB] FAIL memory_%0d: got pc=%h instr=%h cyc=%0d rd=%0d alu=%0d dv=%0d wr=%0d we=%b trap=%b, required pc=%h instr=%h cyc=%0d rd=%0d alu=%0d dv=%0d wr=%0d we=%b trap=0",
                 i, obs.pc, obs.instr, obs.cycles, obs.rd, obs.alu, obs.dv, obs.wr, obs.we, tr,
                 exp.pc, exp.instr, exp.cycles, exp.rd, exp.alu, exp.dv, exp.wr, exp.we);
      end
    end
`ifdef SEQ_PERF_CNT_EN
    tests_run++;
    if (instret !== 32'(retired)) begin
      tests_failed++;
      $display("[TB] FAIL instret_count: got %0d, required %0d", instret, retired);
    end
`endif
  endtask

  task automatic test_traps();
    logic [31:0] t_instr[3] = '{32'h0000_0000, 32'h0000_0073, 32'h0010_0073};
    logic [15:0] t_uc[3]    = '{16'h0080, 16'h0040, 16'h00C0};
    logic [1:0]  t_cause[3] = '{CAUSE_ILLEGAL, CAUSE_ENV, CAUSE_ILLEGAL};
    retire_t     obs;
    bit          tr;
    int          fetch_seen;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      model_pc = RESET_PC + 32'd4;
      drive_instr(32'h0010_0093, 16'h0003, 1'b0, 32'h0, 0, 0, obs, tr);
      drive_instr(t_instr[i], t_uc[i], 1'b0, 32'h0, 0, 0, obs, tr);
      tests_run++;
      if (!tr || trap_cause !== t_cause[i] || pc !== model_pc) begin
        tests_failed++;
        $display("[TB] FAIL trap_%0d: got trap=%b cause=%0d pc=%h, required 1 %0d %h", i, tr, trap_cause, pc, t_cause[i], model_pc);
      end
      fetch_seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (imem_req_valid || !trap) fetch_seen++;
      end
      tests_run++;
      if (fetch_seen != 0) begin
        tests_failed++;
        $display("[TB] FAIL trap_sticky_%0d: got %0d cycles with fetch or trap low, required 0", i, fetch_seen);
      end
    end
  endtask

  task automatic test_timeout();
    int iwait_cycles = 0;
    bit back = 0;
    do_reset();
    @(negedge clk);
    imem_req_ready = 1'b1;
    for (int k = 0; k < 40 && !trap; k++) begin
      @(negedge clk);
      imem_req_ready = 1'b0;
      if (!trap && !imem_req_valid) iwait_cycles++;
    end
    tests_run++;
    if (!trap || trap_cause !== CAUSE_BUS || iwait_cycles != MEM_TIMEOUT || pc !== RESET_PC) begin
      tests_failed++;
      $display("[TB] FAIL iwait_timeout: got trap=%b cause=%0d iwait=%0d pc=%h, required 1 3 %0d %h",
               trap, trap_cause, iwait_cycles, pc, MEM_TIMEOUT, RESET_PC);
    end
    // Response arriving on the last allowed IWAIT cycle must win over the timeout.
    do_reset();
    @(negedge clk);
    imem_req_ready = 1'b1;
    for (int k = 1; k <= MEM_TIMEOUT; k++) begin
      @(negedge clk);
      imem_req_ready = 1'b0;
      if (k == MEM_TIMEOUT) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        microcode      = 16'h0003;
      end
    end
    for (int k = 0; k < 30 && !back; k++) begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (imem_req_valid || trap) back = 1;
    end
    tests_run++;
    if (trap !== 1'b0 || pc !== RESET_PC + 32'd4 || !back) begin
      tests_failed++;
      $display("[TB] FAIL iwait_last_cycle: got trap=%b pc=%h back=%b, required 0 %h 1", trap, pc, back, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_reset_mwait();
    retire_t obs, exp;
    bit      tr;
    do_reset();
    drive_instr(32'h0010_0093, 16'h0003, 1'b0, 32'h0, 0, 0, obs, tr);
    drive_instr(32'h0000_A083, 16'h000B, 1'b0, 32'h0, 1, 1, obs, tr);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({imem_req_valid, dmem_req_valid, rf_wr_en, alu_en, trap} !== 5'b0 || pc !== RESET_PC || instr !== NOP_INSTR) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_mwait: got strobes=%b pc=%h instr=%h, required 0 %h %h",
               {imem_req_valid, dmem_req_valid, rf_wr_en, alu_en, trap}, pc, instr, RESET_PC, NOP_INSTR);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC || dmem_req_valid !== 1'b0 || rf_wr_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL late_rsp_ignored: got ivalid=%b addr=%h dvalid=%b wr=%b, required 1 %h 0 0",
               imem_req_valid, imem_addr, dmem_req_valid, rf_wr_en, RESET_PC);
    end
    model_pc = RESET_PC;
    exp = model(model_pc, 32'h0010_0093, 16'h0003, 1'b0, 32'h0, 0);
    sb.push_back(exp);
    model_pc = exp.pc;
    drive_instr(32'h0010_0093, 16'h0003, 1'b0, 32'h0, 0, 0, obs, tr);
    exp = sb.pop_front();
    tests_run++;
    if (obs.pc !== exp.pc || obs.wr !== exp.wr || tr) begin
      tests_failed++;
      $display("[TB] FAIL restart_after_reset: got pc=%h wr=%0d trap=%b, required %h %0d 0", obs.pc, obs.wr, tr, exp.pc, exp.wr);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_memory();
    test_traps();
    test_timeout();
    test_reset_mwait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, required completion before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Fetches instructions over a valid/ready instruction-memory port and holds the instruction register that feeds instruction_decoder.
- Waits out the synchronous microcode ROM latency, then steps each instruction through register read, execute, memory and writeback, as enabled by the 16-bit microcode word.
- Owns the PC and the trap/halt state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 16, max cycles waiting for any memory response before a bus-error trap (range 2..255).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  fetch request accepted this cycle when both high.
- imem_addr  out  32  fetch address, equals pc.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction.
- instr  out  32  instruction register, driven to the decoder.
- microcode  in  16  decoder ROM output, valid 1 cycle after instr changes.
- rf_rd_en  out  1  register-file read strobe.
- alu_en  out  1  execute strobe.
- branch_taken  in  1  ALU redirect decision, sampled in EXEC.
- target_pc  in  32  redirect target, sampled in EXEC.
- dmem_req_valid  out  1  data request valid.
- dmem_req_ready  in  1  data request accepted.
- dmem_we  out  1  1 = store, 0 = load; held with dmem_req_valid.
- dmem_rsp_valid  in  1  load data / store ack.
- rf_wr_en  out  1  register-file write strobe.
- pc  out  32  current PC.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 none, 1 illegal, 2 ecall/ebreak, 3 bus timeout.

Behaviour:
- Microcode bits:
  - bit0 has_rd, bit1 has_rs1, bit2 has_rs2.
  - bit3 mem, bit4 mem_write, bit5 pc_redirect.
  - bit6 env (ecall/ebreak), bit7 illegal.
  - Bits 15:8 pass through to the datapath and are ignored here.
  - ROM word 0 (the decoder default) has bit7 set.
- Reset values: all strobes and valids 0, pc = RESET_PC, instr = 32'h0000_0013 (NOP), trap = 0, trap_cause = 0, state FETCH.
- States: FETCH, IWAIT, DECODE, RREAD, EXEC, MREQ, MWAIT, WB, TRAP.
- FETCH:
  - imem_req_valid = 1.
  - On valid && ready, go to IWAIT.
  - imem_addr is stable while valid is high and not yet accepted.
- IWAIT:
  - On imem_rsp_valid, latch instr and go to DECODE.
  - A response in any other state is ignored.
- DECODE: one-cycle ROM latency. microcode is sampled at the end of DECODE into uc_q. Priority order:
  - illegal → TRAP (cause 1);
  - env → TRAP (cause 2);
  - has_rs1 | has_rs2 → RREAD;
  - else → EXEC.
- RREAD: rf_rd_en = 1 for one cycle, then EXEC.
- EXEC:
  - alu_en = 1 for one cycle.
  - If uc_q.pc_redirect && branch_taken: next_pc = target_pc; else next_pc = pc + 4 (mod 2^32, wraps silently).
  - Next state: mem → MREQ; else has_rd → WB; else retire.
- MREQ:
  - dmem_req_valid = 1, dmem_we = uc_q.mem_write.
  - On accept, go to MWAIT.
- MWAIT: on dmem_rsp_valid: has_rd → WB, else retire.
- WB: rf_wr_en = 1 for one cycle, then retire.
- Retire: pc ← next_pc; return to FETCH next cycle.
- Timeout:
  - A wait counter clears on entering IWAIT, MREQ or MWAIT and increments each stalled cycle in FETCH/IWAIT/MREQ/MWAIT.
  - On reaching MEM_TIMEOUT, go to TRAP with cause 3.
  - A handshake completing in the same cycle the count reaches MEM_TIMEOUT wins; no trap.
- TRAP:
  - trap = 1, all strobes and valids 0, pc frozen at the faulting instruction.
  - Exit only by reset.
- rst_n low in any state: immediate return to reset values. Outstanding memory responses arriving after reset are ignored (IWAIT/MWAIT are not entered without a new request).
- Strobes are registered Moore outputs derived from state only.

Optional Feature:
- SEQ_PERF_CNT_EN: adds output instret[31:0].
  - Resets to 0, increments on each retire, wraps at 2^32.
  - Does not increment on TRAP.
- Without the macro: no port, no counter logic.

Decomposition:
- Shared package core_pkg:
  - microcode bit-index constants (UC_HAS_RD … UC_ILLEGAL);
  - state enum encoding;
  - trap_cause constants;
  - NOP_INSTR constant.
- No sub-module. Optional split: seq_wait_timer, holding the timeout counter with clear/inc/expired.

Test Plan:
- ADDI at RESET_PC 0, imem ready/rsp immediate → FETCH,IWAIT,DECODE,RREAD,EXEC,WB; pc = 4 at cycle 7; rf_wr_en pulsed once.
- SW with dmem_req_ready delayed 3 cycles → dmem_req_valid held 4 cycles with dmem_we = 1; no rf_wr_en; pc = pc+4.
- Taken BEQ, target_pc = 0x100 → pc = 0x100 after retire. Not-taken → pc+4. pc at 0xFFFF_FFFC non-branch → wraps to 0.
- Instruction 0x0000_0000 (microcode 0 / illegal) → trap = 1, cause 1, pc unchanged, no further imem_req_valid.
- imem_rsp_valid never asserted, MEM_TIMEOUT = 16 → trap cause 3 after 16 IWAIT cycles. Response on cycle 16 → no trap.
- rst_n pulsed low during MWAIT → outputs at reset values asynchronously; late dmem_rsp_valid ignored; fetch restarts at RESET_PC.
